// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver for a BCD adder result.
// Latches sum/carry on load; drives units/tens alternately with guard-band blanking.
module bcd_display_mux #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned GUARD         = 2,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] sum,
    input  logic       carry,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_ONE   = 7'h79;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    logic [CNT_W-1:0] cnt;
    logic             sel;
    logic [3:0]       u_q;
    logic             t_q;

    logic [6:0]       seg_c;
    logic [1:0]       an_c;
    logic             err_c;
    logic             bad_c;
    logic             wrap_c;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD shows 'E'.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

    assign bad_c  = (u_q > 4'd9);
    assign wrap_c = (cnt == CNT_MAX);

    // Next-output selection from the pre-edge prescaler and latch state.
    always_comb begin
        an_c  = AN_OFF;
        seg_c = SEG_BLANK;
        err_c = bad_c;
        if (cnt >= GUARD_END) begin
            if (!sel) begin
                an_c  = AN_UNITS;
                seg_c = bad_c ? SEG_E : decode(u_q);
            end else if (bad_c) begin
                an_c  = AN_TENS;
                seg_c = SEG_E;
            end else if (t_q) begin
                an_c  = AN_TENS;
                seg_c = SEG_ONE;
            end else if (!BLANK_LEADING) begin
                an_c  = AN_TENS;
                seg_c = SEG_ZERO;
            end
        end
    end

    // Prescaler, digit latch and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sel <= 1'b0;
            u_q <= 4'd0;
            t_q <= 1'b0;
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            err <= 1'b0;
        end else begin
            cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
            sel <= sel ^ wrap_c;
            if (load) begin
                u_q <= sum;
                t_q <= carry;
            end
            an  <= an_c;
            seg <= seg_c;
            err <= err_c;
        end
    end

endmodule
